// File: rtl/boot_uart_rx_if.sv
// Bus bundle for boot_uart_rx.
//   master : the receiver side (boot_uart_rx). Takes the serial line and mode,
//            drives the byte-report and memory-write signals.
//   slave  : the pin/loader side. Drives rx and load_en, consumes the rest.
// Signals:
//   rx         UART serial line, idle high, asynchronous to clk
//   load_en    bootload mode; word packing and writes enabled while high
//   byte_data  last good received byte
//   byte_valid 1-cycle pulse, byte_data updated
//   frame_err  1-cycle pulse, stop bit sampled low
//   wr_en      1-cycle memory write strobe
//   wr_addr    word address for the current or next write
//   wr_data    assembled little-endian word
//   done       sticky, last address written; cleared while load_en is low
interface boot_uart_rx_if #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 8
);
    logic                    rx;
    logic                    load_en;
    logic [7:0]              byte_data;
    logic                    byte_valid;
    logic                    frame_err;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*WORD_BYTES-1:0] wr_data;
    logic                    done;

    modport master (
        input  rx, load_en,
        output byte_data, byte_valid, frame_err, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        output rx, load_en,
        input  byte_data, byte_valid, frame_err, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/boot_uart_rx.sv
// Bootloader serial front end: 8N1 UART receiver plus a little-endian word
// packer that issues one write strobe per completed word with an
// auto-incrementing address.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active high
//   ce   clock enable for the receive FSM, its counters and the pulse sources
//   bus  boot_uart_rx_if.master (serial input, byte report, memory write port)
// Parameters:
//   DIV        clk cycles per UART bit, >= 4
//   WORD_BYTES bytes per memory word, 1..4
//   ADDR_W     width of wr_addr; the address wraps at 2**ADDR_W
module boot_uart_rx #(
    parameter int DIV        = 434,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    boot_uart_rx_if.master bus
);
    localparam int CNT_W  = $clog2(DIV);
    localparam int BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_W = 8 * WORD_BYTES;

    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] LAST_LANE = BCNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic                rx_m, rx_s;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          bit_q;
    logic [7:0]          shreg_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [WORD_W-1:0]   word_q, word_next;
    logic                cnt_clr, shift_en, stop_smp;

    // Two-flop synchronizer; free-running so rx never sees a ce-dependent delay.
    // NOTE: every clocked process here uses non-blocking assignments so all
    // flops update together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state. Nothing moves while ce is low.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (ce) begin
            case (state_q)
                IDLE:    if (!rx_s) state_d = START;
                START:   if (cnt_q == HALF_M1) state_d = rx_s ? IDLE : DATA;
                DATA:    if (cnt_q == FULL_M1 && bit_q == 3'd7) state_d = STOP;
                STOP:    if (cnt_q == FULL_M1) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: counter restart, data-bit sample and stop-bit sample.
    // Leaving STOP at mid stop bit lets the next start edge be seen early.
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        stop_smp = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE:  cnt_clr = 1'b1;
                START: cnt_clr = (cnt_q == HALF_M1);
                DATA: begin
                    cnt_clr  = (cnt_q == FULL_M1);
                    shift_en = (cnt_q == FULL_M1);
                end
                STOP:    stop_smp = (cnt_q == FULL_M1);
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    // Bit-period counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else if (ce) begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
            if (state_q == IDLE) begin
                bit_q <= '0;
            end else if (shift_en) begin
                bit_q   <= bit_q + 3'd1;
                shreg_q <= {rx_s, shreg_q[7:1]};
            end
        end
    end

    // Byte report. stop_smp already includes ce, so a pulse is only ever
    // launched from an enabled cycle and lasts exactly one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.byte_data  <= '0;
            bus.byte_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.byte_valid <= stop_smp & rx_s;
            bus.frame_err  <= stop_smp & ~rx_s;
            if (stop_smp && rx_s) bus.byte_data <= shreg_q;
        end
    end

    // Word being assembled with the incoming byte dropped into its lane.
    always_comb begin
        word_next = word_q;
        word_next[{bcnt_q, 3'b000} +: 8] = bus.byte_data;
    end

    // Packer and write port. It reacts to the byte pulses themselves rather
    // than to ce, so each pulse is consumed exactly once even when ce drops
    // in the cycle it is visible.
    // NOTE: word_q is a small register, not a memory array, so it is reset
    // along with everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q      <= '0;
            word_q      <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.done    <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            if (!bus.load_en) begin
                bcnt_q      <= '0;
                bus.wr_addr <= '0;
                bus.done    <= 1'b0;
            end else begin
                if (bus.byte_valid) begin
                    word_q <= word_next;
                    if (bcnt_q == LAST_LANE) begin
                        bcnt_q      <= '0;
                        bus.wr_en   <= 1'b1;
                        bus.wr_data <= word_next;
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                    end
                end else if (bus.frame_err) begin
                    bcnt_q <= '0;   // drop the partial word, keep the address
                end
                if (bus.wr_en) begin
                    bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
                    if (&bus.wr_addr) bus.done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_boot_uart_rx.sv
// Self-checking bench for boot_uart_rx (DIV=8, WORD_BYTES=2, ADDR_W=2).
// A frame-level reference model turns the list of sent frames into the
// expected byte reports, frame errors and memory writes.
module tb_boot_uart_rx;
    localparam int DIV   = 8;
    localparam int WB    = 2;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int NV    = 6;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [8*WB-1:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         rnd_ce;
        logic [7:0] exp_byte;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    boot_uart_rx_if #(.WORD_BYTES(WB), .ADDR_W(AW)) bus ();

    boot_uart_rx #(.DIV(DIV), .WORD_BYTES(WB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observed events.
    logic [7:0] got_bytes[$];
    wr_t        got_wr[$];
    int         got_ferr = 0;
    int         got_both = 0;

    // Reference model state.
    logic [7:0] exp_bytes[$];
    wr_t        exp_wr[$];
    int         exp_ferr = 0;
    logic [7:0] pend[$];
    int         m_addr = 0;
    bit         m_done = 1'b0;

    vec_t vecs[NV];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.byte_valid) got_bytes.push_back(bus.byte_data);
            if (bus.frame_err) got_ferr++;
            if (bus.byte_valid && bus.frame_err) got_both++;
            if (bus.wr_en) got_wr.push_back('{addr: bus.wr_addr, data: bus.wr_data});
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: good bytes are reported; in load mode they are
    // grouped little-endian into words written at consecutive addresses.
    task automatic model_frame(input logic [7:0] d, input bit ok);
        logic [8*WB-1:0] w;
        if (ok) begin
            exp_bytes.push_back(d);
            if (bus.load_en) begin
                pend.push_back(d);
                if (pend.size() == WB) begin
                    w = '0;
                    for (int i = 0; i < WB; i++) w[8*i +: 8] = pend[i];
                    exp_wr.push_back('{addr: AW'(m_addr), data: w});
                    if (m_addr == DEPTH - 1) m_done = 1'b1;
                    m_addr = (m_addr + 1) % DEPTH;
                    pend.delete();
                end
            end
        end else begin
            exp_ferr++;
            pend.delete();
        end
    endtask

    task automatic clear_obs();
        got_bytes.delete();
        got_wr.delete();
        got_ferr = 0;
        got_both = 0;
        exp_bytes.delete();
        exp_wr.delete();
        exp_ferr = 0;
    endtask

    // Hold rx at v for len enabled cycles; called and returns at a negedge.
    task automatic drive_bit(input logic v, input int len, input bit rnd);
        int n;
        n = 0;
        bus.rx = v;
        while (n < len) begin
            ce = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (ce) n++;
        end
    endtask

    // A bad stop bit is held low long enough to be sampled, then released
    // early so the receiver's spurious start check sees the line high again.
    task automatic send_frame(input logic [7:0] d, input bit ok, input bit rnd);
        if (!ok) rnd = 1'b0;
        drive_bit(1'b0, DIV, rnd);
        for (int i = 0; i < 8; i++) drive_bit(d[i], DIV, rnd);
        if (ok) begin
            drive_bit(1'b1, DIV, rnd);
        end else begin
            drive_bit(1'b0, 6, 1'b0);
            drive_bit(1'b1, DIV - 6, 1'b0);
        end
        drive_bit(1'b1, 2 * DIV, 1'b0);
        model_frame(d, ok);
    endtask

    task automatic set_load(input logic v);
        if (!v) begin
            pend.delete();
            m_addr = 0;
            m_done = 1'b0;
        end
        bus.load_en = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s byte_data", tag), 32'(bus.byte_data), 32'h0);
        check($sformatf("%s byte_valid", tag), 32'(bus.byte_valid), 32'h0);
        check($sformatf("%s frame_err", tag), 32'(bus.frame_err), 32'h0);
        check($sformatf("%s wr_en", tag), 32'(bus.wr_en), 32'h0);
        check($sformatf("%s wr_addr", tag), 32'(bus.wr_addr), 32'h0);
        check($sformatf("%s wr_data", tag), 32'(bus.wr_data), 32'h0);
        check($sformatf("%s done", tag), 32'(bus.done), 32'h0);
    endtask

    task automatic checkpoint(input string tag);
        check($sformatf("%s byte count", tag), 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
        check($sformatf("%s frame_err count", tag), 32'(got_ferr), 32'(exp_ferr));
        check($sformatf("%s write count", tag), 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s write%0d {addr,data}", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
        check($sformatf("%s done", tag), 32'(bus.done), 32'(m_done));
        check($sformatf("%s wr_addr", tag), 32'(bus.wr_addr), 32'(m_addr));
        check($sformatf("%s valid+err overlap", tag), 32'(got_both), 32'h0);
        clear_obs();
    endtask

    task automatic apply_reset(input string tag);
        rst    = 1'b1;
        ce     = 1'b1;
        bus.rx = 1'b1;
        pend.delete();
        m_addr = 0;
        m_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(tag);
        rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        logic [7:0] d;
        bit         ok, rnd;

        rst         = 1'b1;
        ce          = 1'b1;
        bus.rx      = 1'b1;
        bus.load_en = 1'b0;

        // data, stop_ok, rnd_ce, expected byte_data, valid pulses, error pulses
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 8'h00, 0, 1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 0, 1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1, 0};

        // Reset state and a quiet idle line.
        repeat (3) @(negedge clk);
        apply_reset("reset");
        repeat (100) @(negedge clk);
        checkpoint("idle");

        // Single frames with load_en low: byte report only, never a write.
        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].rnd_ce);
            check($sformatf("vec%0d byte_valid pulses", i), 32'(got_bytes.size()), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d frame_err pulses", i), 32'(got_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d byte_data", i), 32'(bus.byte_data), 32'(vecs[i].exp_byte));
            check($sformatf("vec%0d writes", i), 32'(got_wr.size()), 32'h0);
            clear_obs();
        end

        // Start-bit glitch of 3 cycles, then a normal frame.
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        checkpoint("glitch");
        send_frame(8'hC3, 1'b1, 1'b0);
        checkpoint("after glitch");

        // Two words in load mode.
        set_load(1'b1);
        send_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h78, 1'b1, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0);
        check("two words count", 32'(got_wr.size()), 32'd2);
        if (got_wr.size() >= 2) begin
            check("word0 {addr,data}", 32'(got_wr[0]), 32'h0_1234);
            check("word1 {addr,data}", 32'(got_wr[1]), 32'h1_5678);
        end
        checkpoint("two words");

        // Framing error drops the partial word; next word lands at addr 2.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h99, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        check("ferr pulses", 32'(got_ferr), 32'd1);
        check("ferr word count", 32'(got_wr.size()), 32'd1);
        if (got_wr.size() >= 1) check("ferr word {addr,data}", 32'(got_wr[0]), 32'h2_3322);
        checkpoint("frame error");

        // Full pass over memory, with ce gaps in two frames; then wrap.
        set_load(1'b0);
        set_load(1'b1);
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom), 1'b1, (k == 3 || k == 6));
            if (k == 5) checkpoint("three words");
        end
        check("done after last addr", 32'(bus.done), 32'h1);
        checkpoint("four words");
        send_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0);
        checkpoint("after wrap");

        // Reset in the middle of a frame with a half-filled word pending.
        send_frame(8'h44, 1'b1, 1'b0);
        checkpoint("before abort");
        drive_bit(1'b0, DIV, 1'b0);
        drive_bit(1'b1, DIV, 1'b0);
        drive_bit(1'b0, DIV, 1'b0);
        apply_reset("abort reset");
        repeat (12 * DIV) @(negedge clk);
        checkpoint("after abort");
        send_frame(8'hAB, 1'b1, 1'b0);
        send_frame(8'hCD, 1'b1, 1'b0);
        checkpoint("post abort word");

        // Randomized frames against the model.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) set_load(~bus.load_en);
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 7) != 0);
            rnd = ($urandom_range(0, 3) == 0);
            send_frame(d, ok, rnd);
            if (k % 10 == 9) checkpoint($sformatf("random%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
